// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_arb_pkg;

    // IDLE arbitrates every beat; LOCKED holds the grant until the packet's last beat.
    typedef enum logic [0:0] {idle_s, locked_s} arb_state_e;

    // Modular increment used both for the search walk and for advancing the pointer.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester found starting at ptr.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int num_req_p = 4,
    parameter int idx_w     = 2
) (
    input  logic [num_req_p-1:0] req,
    input  logic [idx_w-1:0]     ptr,
    output logic [num_req_p-1:0] grant,
    output logic [idx_w-1:0]     idx,
    output logic                 found
);

    int k;

    // Walk ptr, ptr+1, ... with wraparound and latch onto the first active request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = int'(ptr);
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = idx_w'(k);
            end
            k = next_idx(k, num_req_p);
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among several streams,
// with optional packet lock that holds the grant until the winner's last beat.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int num_req_p     = 4,
    parameter int width_p       = 8,
    parameter int packet_mode_p = 1,
    localparam int idx_w        = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [num_req_p-1:0]         valid_i,
    input  logic [num_req_p*width_p-1:0] data_i,
    input  logic [num_req_p-1:0]         last_i,
    output logic [num_req_p-1:0]         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    output logic                         last_o,
    output logic [idx_w-1:0]             src_o,
    input  logic                         ready_i
);

    arb_state_e           state_r, state_n;
    logic [idx_w-1:0]     ptr_r, ptr_n;
    logic [idx_w-1:0]     lock_r, lock_n;
    logic [num_req_p-1:0] pick_grant;
    logic [idx_w-1:0]     pick_idx;
    logic                 pick_found;
    logic [idx_w-1:0]     winner;
    logic                 winner_ok;
    logic                 can_load;
    logic                 fire;
    logic [width_p-1:0]   data_arr [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign data_arr[g] = data_i[g*width_p +: width_p];
    end

    // Output slot can take a new beat when empty or being drained this cycle; never in reset.
    assign can_load = reset_ni & (~valid_o | ready_i);

    rr_pick #(
        .num_req_p (num_req_p),
        .idx_w     (idx_w)
    ) u_pick (
        .req   (valid_i),
        .ptr   (ptr_r),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Choose the winner, drive its ready and work out pointer/lock/state for the next cycle.
    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        lock_n    = lock_r;
        ready_o   = '0;
        winner    = pick_idx;
        winner_ok = pick_found;
        if (state_r == locked_s) begin
            winner    = lock_r;
            winner_ok = 1'b1;
        end
        if (can_load && winner_ok) begin
            ready_o[winner] = 1'b1;
        end
        fire = |(valid_i & ready_o);
        if (fire) begin
            if (packet_mode_p == 0 || last_i[winner]) begin
                ptr_n   = idx_w'(next_idx(int'(winner), num_req_p));
                state_n = idle_s;
            end else begin
                lock_n  = winner;
                state_n = locked_s;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= idle_s;
            ptr_r   <= '0;
            lock_r  <= '0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            lock_r  <= lock_n;
        end
    end

    // One-entry output register: load on transfer, otherwise empty once downstream takes it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            src_o   <= '0;
        end else if (fire) begin
            valid_o <= 1'b1;
            data_o  <= data_arr[winner];
            last_o  <= last_i[winner];
            src_o   <= winner;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Self-checking bench: two arbiters (per-beat and packet mode) share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed scenarios.
module tb_rr_stream_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] valid_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0] last_i;
    logic         ready_i;

    logic [N-1:0] ready0, ready1;
    logic         vo0, vo1;
    logic [W-1:0] do0, do1;
    logic         lo0, lo1;
    logic [1:0]   so0, so1;

    int checks;
    int failures;

    // Model state, index 0 = per-beat arbiter, index 1 = packet-lock arbiter
    int       m_ptr   [2];
    bit       m_lock  [2];
    int       m_owner [2];
    bit       m_ov    [2];
    logic [W-1:0] m_od [2];
    bit       m_ol    [2];
    int       m_os    [2];

    int q0[$];
    int q1[$];

    rr_stream_arbiter #(.num_req_p(N), .width_p(W), .packet_mode_p(0)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .valid_i(valid_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready0), .valid_o(vo0), .data_o(do0),
        .last_o(lo0), .src_o(so0), .ready_i(ready_i)
    );

    rr_stream_arbiter #(.num_req_p(N), .width_p(W), .packet_mode_p(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .valid_i(valid_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready1), .valid_o(vo1), .data_o(do1),
        .last_o(lo1), .src_o(so1), .ready_i(ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge, drive inputs, let logic settle.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d,
                                 input logic [N-1:0] l, input logic r);
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        last_i  = l;
        ready_i = r;
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        valid_i = '0;
        last_i  = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    function automatic int modelWinner(input int m);
        if (m_lock[m]) return m_owner[m];
        for (int i = 0; i < N; i++) begin
            if (valid_i[(m_ptr[m] + i) % N]) return (m_ptr[m] + i) % N;
        end
        return -1;
    endfunction

    // Per-cycle compare against the model at the falling edge, then advance the model.
    initial begin
        logic [N-1:0] exp_rdy;
        int           w;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!reset_n) begin
                    m_ptr[m] = 0; m_lock[m] = 0; m_owner[m] = 0;
                    m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0;
                end
                w = modelWinner(m);
                exp_rdy = '0;
                if (reset_n && (!m_ov[m] || ready_i) && w >= 0) exp_rdy[w] = 1'b1;
                checkOutput($sformatf("m%0d valid_o", m), (m == 0) ? 32'(vo0) : 32'(vo1), 32'(m_ov[m]));
                checkOutput($sformatf("m%0d data_o", m), (m == 0) ? 32'(do0) : 32'(do1), 32'(m_od[m]));
                checkOutput($sformatf("m%0d last_o", m), (m == 0) ? 32'(lo0) : 32'(lo1), 32'(m_ol[m]));
                checkOutput($sformatf("m%0d src_o", m), (m == 0) ? 32'(so0) : 32'(so1), 32'(m_os[m]));
                checkOutput($sformatf("m%0d ready_o", m), (m == 0) ? 32'(ready0) : 32'(ready1), 32'(exp_rdy));
                if (reset_n) begin
                    if (exp_rdy != '0 && valid_i[w]) begin
                        m_ov[m] = 1; m_od[m] = data_i[w*W +: W]; m_ol[m] = last_i[w]; m_os[m] = w;
                        if (m == 0 || last_i[w]) begin
                            m_ptr[m] = (w + 1) % N;
                            m_lock[m] = 0;
                        end else begin
                            m_lock[m] = 1;
                            m_owner[m] = w;
                        end
                    end else if (ready_i) begin
                        m_ov[m] = 0;
                    end
                end
            end
            if (vo0 && ready_i) q0.push_back(int'(so0));
            if (vo1 && ready_i) q1.push_back(int'(so1));
        end
    end

    initial begin
        logic [N-1:0] rl;
        int exp_rr [6];
        int exp_pk [4];
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        valid_i  = '0;
        data_i   = '0;
        last_i   = '0;
        ready_i  = 1'b1;

        // Reset held with every requester valid: nothing granted, nothing out
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        data_i  = 32'h44332211;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready0", 32'(ready0), 32'h0);
        checkOutput("reset ready1", 32'(ready1), 32'h0);
        checkOutput("reset valid0", 32'(vo0), 32'h0);
        checkOutput("reset valid1", 32'(vo1), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("first grant0", 32'(ready0), 32'h1);
        checkOutput("first grant1", 32'(ready1), 32'h1);

        // Round robin at full load
        q0.delete();
        q1.delete();
        repeat (7) applyStimulus(4'b1111, 32'h44332211, 4'b1111, 1'b1);
        exp_rr = '{0, 1, 2, 3, 0, 1};
        checkOutput("rr count0", 32'(q0.size()), 32'd6);
        checkOutput("rr count1", 32'(q1.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q0.size()) checkOutput($sformatf("rr src0[%0d]", i), 32'(q0[i]), 32'(exp_rr[i]));
            if (i < q1.size()) checkOutput($sformatf("rr src1[%0d]", i), 32'(q1[i]), 32'(exp_rr[i]));
        end

        // Packet lock: req0 sends three beats with a gap, req1 waits
        doReset();
        q1.delete();
        applyStimulus(4'b0011, 32'h0000B1A1, 4'b0000, 1'b1);
        checkOutput("lock c1 ready1", 32'(ready1), 32'h1);
        applyStimulus(4'b0010, 32'h0000B1A2, 4'b0000, 1'b1);
        checkOutput("lock gap ready1", 32'(ready1), 32'h1);
        applyStimulus(4'b0011, 32'h0000B1A2, 4'b0000, 1'b1);
        checkOutput("lock c3 ready1", 32'(ready1), 32'h1);
        applyStimulus(4'b0011, 32'h0000B1A3, 4'b0001, 1'b1);
        applyStimulus(4'b0010, 32'h0000B1A3, 4'b0010, 1'b1);
        checkOutput("unlock ready1", 32'(ready1), 32'h2);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b1);
        exp_pk = '{0, 0, 0, 1};
        checkOutput("lock count", 32'(q1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q1.size()) checkOutput($sformatf("lock src[%0d]", i), 32'(q1[i]), 32'(exp_pk[i]));
        end

        // Backpressure: held beat stays put, next beat loads as it drains
        doReset();
        applyStimulus(4'b0001, 32'h0000BBAA, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 32'h0000BBAA, 4'b1111, 1'b0);
            checkOutput("stall ready1", 32'(ready1), 32'h0);
            checkOutput("stall ready0", 32'(ready0), 32'h0);
            checkOutput("stall valid1", 32'(vo1), 32'h1);
            checkOutput("stall data1", 32'(do1), 32'hAA);
            checkOutput("stall src1", 32'(so1), 32'h0);
        end
        applyStimulus(4'b0010, 32'h0000BBAA, 4'b1111, 1'b1);
        checkOutput("drain ready1", 32'(ready1), 32'h2);
        applyStimulus(4'b0000, 32'h0000BBAA, 4'b1111, 1'b1);
        checkOutput("reload valid1", 32'(vo1), 32'h1);
        checkOutput("reload data1", 32'(do1), 32'hBB);
        checkOutput("reload src1", 32'(so1), 32'h1);

        // Wrap with sparse requesters starting from pointer 2
        doReset();
        applyStimulus(4'b0010, 32'h0, 4'b1111, 1'b1);
        checkOutput("wrap setup", 32'(ready1), 32'h2);
        applyStimulus(4'b1010, 32'h0, 4'b1111, 1'b1);
        checkOutput("wrap g1 m1", 32'(ready1), 32'h8);
        checkOutput("wrap g1 m0", 32'(ready0), 32'h8);
        applyStimulus(4'b1010, 32'h0, 4'b1111, 1'b1);
        checkOutput("wrap g2 m1", 32'(ready1), 32'h2);
        checkOutput("wrap g2 m0", 32'(ready0), 32'h2);
        applyStimulus(4'b1010, 32'h0, 4'b1111, 1'b1);
        checkOutput("wrap g3 m1", 32'(ready1), 32'h8);

        // Asynchronous reset in the middle of a locked packet from req2
        doReset();
        applyStimulus(4'b0100, 32'h00C10000, 4'b0000, 1'b1);
        checkOutput("mid lock ready1", 32'(ready1), 32'h4);
        applyStimulus(4'b0100, 32'h00C20000, 4'b0000, 1'b1);
        checkOutput("mid valid1", 32'(vo1), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async valid1", 32'(vo1), 32'h0);
        checkOutput("async ready1", 32'(ready1), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        valid_i = 4'b0101;
        last_i  = 4'b1111;
        #1;
        checkOutput("post reset ready1", 32'(ready1), 32'h1);
        checkOutput("post reset valid1", 32'(vo1), 32'h0);

        // Randomised traffic, checked every cycle by the model
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) rl[b] = ($urandom % 3) == 0;
            applyStimulus(4'($urandom_range(0, 15)), $urandom, rl, ($urandom % 4) != 0);
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
